// File: rtl/serv_bus_arbiter.sv
// Two-to-one Wishbone arbiter sharing one master port between ibus and dbus.
// Define SERV_ARB_TIMEOUT_EN to add a watchdog that force-acks stalled cycles.
module serv_bus_arbiter #(
  parameter int AW   = 32,
  parameter int TO_W = 8
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic [AW-1:0] i_ibus_adr,
  input  logic          i_ibus_cyc,
  output logic [31:0]   o_ibus_rdt,
  output logic          o_ibus_ack,
  input  logic [AW-1:0] i_dbus_adr,
  input  logic [31:0]   i_dbus_dat,
  input  logic [3:0]    i_dbus_sel,
  input  logic          i_dbus_we,
  input  logic          i_dbus_cyc,
  output logic [31:0]   o_dbus_rdt,
  output logic          o_dbus_ack,
  output logic [AW-1:0] o_wb_adr,
  output logic [31:0]   o_wb_dat,
  output logic [3:0]    o_wb_sel,
  output logic          o_wb_we,
  output logic          o_wb_cyc,
  input  logic [31:0]   i_wb_rdt,
  input  logic          i_wb_ack,
  output logic          o_err,
  output logic          o_busy
);

  typedef enum logic [1:0] {S_IDLE, S_IBUS, S_DBUS} state_t;

  typedef struct packed {
    logic [AW-1:0] adr;
    logic [31:0]   dat;
    logic [3:0]    sel;
    logic          we;
  } wb_req_t;

  state_t  state_q;
  logic    cyc_q;
  logic    last_dbus_q;   // 1: dbus held the most recent grant
  logic    to_fire;
  logic    done;
  wb_req_t ireq, dreq, wreq;

`ifdef SERV_ARB_TIMEOUT_EN
  localparam logic [TO_W-1:0] CNT_MAX = '1;
  logic [TO_W-1:0] cnt_q;

  // Counter sits at zero in IDLE, so every grant starts a fresh count.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                 cnt_q <= '0;
    else if (state_q == S_IDLE)   cnt_q <= '0;
    else if (!i_wb_ack)           cnt_q <= cnt_q + 1'b1;
  end

  // A genuine ack in the same cycle takes precedence over the watchdog.
  assign to_fire = (state_q != S_IDLE) && (cnt_q == CNT_MAX) && !i_wb_ack;
`else
  logic unused_to_w;
  assign unused_to_w = ^TO_W;
  assign to_fire     = 1'b0;
`endif

  assign done = i_wb_ack | to_fire;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      cyc_q       <= 1'b0;
      last_dbus_q <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (i_ibus_cyc && (!i_dbus_cyc || last_dbus_q)) begin
            state_q     <= S_IBUS;
            cyc_q       <= 1'b1;
            last_dbus_q <= 1'b0;
          end else if (i_dbus_cyc) begin
            state_q     <= S_DBUS;
            cyc_q       <= 1'b1;
            last_dbus_q <= 1'b1;
          end
        end
        S_IBUS: begin
          if (done || !i_ibus_cyc) begin
            state_q <= S_IDLE;
            cyc_q   <= 1'b0;
          end
        end
        S_DBUS: begin
          if (done || !i_dbus_cyc) begin
            state_q <= S_IDLE;
            cyc_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          cyc_q   <= 1'b0;
        end
      endcase
    end
  end

  // Instruction fetches are always full-word reads.
  assign ireq = '{adr: i_ibus_adr, dat: 32'h0, sel: 4'hf, we: 1'b0};
  assign dreq = '{adr: i_dbus_adr, dat: i_dbus_dat, sel: i_dbus_sel, we: i_dbus_we};

  always_comb begin
    wreq = ireq;
    if (state_q == S_DBUS) wreq = dreq;
  end

  assign o_wb_adr   = wreq.adr;
  assign o_wb_dat   = wreq.dat;
  assign o_wb_sel   = wreq.sel;
  assign o_wb_we    = wreq.we;
  assign o_wb_cyc   = cyc_q;

  assign o_ibus_ack = (state_q == S_IBUS) & done;
  assign o_dbus_ack = (state_q == S_DBUS) & done;
  assign o_ibus_rdt = to_fire ? 32'h0 : i_wb_rdt;
  assign o_dbus_rdt = to_fire ? 32'h0 : i_wb_rdt;
  assign o_err      = to_fire;
  assign o_busy     = (state_q != S_IDLE);

endmodule
